// File: rtl/pc_predict.sv
// Fetch-address generator with a direct-mapped BTB and 2-bit direction counters.
// Lookup is combinational on the registered PC. EX trains the table and redirects the PC.
module pc_predict #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    STEP        = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [5:0]            stall_in,
  input  logic                  ex_redirect_in,
  input  logic [ADDR_WIDTH-1:0] ex_redirect_addr_in,
  input  logic                  ex_br_valid_in,
  input  logic [ADDR_WIDTH-1:0] ex_br_pc_in,
  input  logic                  ex_br_taken_in,
  input  logic [ADDR_WIDTH-1:0] ex_br_target_in,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pred_taken_out,
  output logic [ADDR_WIDTH-1:0] pred_target_out
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  // Per-entry state lives in flops so reset can clear every valid bit at once
  logic                  valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]      tag_q    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [1:0]            ctr_q    [BTB_ENTRIES];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [ADDR_WIDTH-1:0] fall_through;

  logic [IDX_W-1:0]      upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  upd_we;
  logic [1:0]            upd_ctr;
  logic [ADDR_WIDTH-1:0] upd_target;

  // Lookup on the current fetch address
  assign lk_idx       = pc_q[IDX_W+1:2];
  assign lk_tag       = pc_q[ADDR_WIDTH-1:IDX_W+2];
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign fall_through = pc_q + ADDR_WIDTH'(STEP);

  assign pc_out          = pc_q;
  assign pred_taken_out  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_out = pred_taken_out ? target_q[lk_idx] : fall_through;

  // Redirect outranks a same-cycle advance
  always_comb begin
    pc_d = pc_q;
    if (rdy_in) begin
      if (ex_redirect_in)
        pc_d = ex_redirect_addr_in;
      else if (stall_in[0])
        pc_d = pred_target_out;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  // Training: saturating counter on a hit, allocate with weakly-taken on a taken miss
  assign upd_idx = ex_br_pc_in[IDX_W+1:2];
  assign upd_tag = ex_br_pc_in[ADDR_WIDTH-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_we     = 1'b0;
    upd_ctr    = ctr_q[upd_idx];
    upd_target = target_q[upd_idx];
    if (rdy_in && ex_br_valid_in) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (ex_br_taken_in) begin
          upd_target = ex_br_target_in;
          if (ctr_q[upd_idx] != 2'b11)
            upd_ctr = ctr_q[upd_idx] + 2'b01;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          upd_ctr = ctr_q[upd_idx] - 2'b01;
        end
      end else if (ex_br_taken_in) begin
        upd_we     = 1'b1;
        upd_ctr    = 2'b10;
        upd_target = ex_br_target_in;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          valid_q[gi]  <= 1'b0;
          tag_q[gi]    <= '0;
          target_q[gi] <= '0;
          ctr_q[gi]    <= 2'b01;
        end else if (upd_we && (upd_idx == IDX_W'(gi))) begin
          valid_q[gi]  <= 1'b1;
          tag_q[gi]    <= upd_tag;
          target_q[gi] <= upd_target;
          ctr_q[gi]    <= upd_ctr;
        end
      end
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{stall_in[5:1], ex_br_pc_in[1:0]};

endmodule

// File: tb/tb_pc_predict.sv
// Directed-vector bench for pc_predict: reset, advance, redirect, training,
// hysteresis, aliasing, freeze, wrap and mid-run reset.
module tb_pc_predict;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic        ex_redirect_in;
  logic [31:0] ex_redirect_addr_in;
  logic        ex_br_valid_in;
  logic [31:0] ex_br_pc_in;
  logic        ex_br_taken_in;
  logic [31:0] ex_br_target_in;
  logic [31:0] pc_out;
  logic        pred_taken_out;
  logic [31:0] pred_target_out;

  int n_vec  = 0;
  int n_miss = 0;

  pc_predict dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .stall_in            (stall_in),
    .ex_redirect_in      (ex_redirect_in),
    .ex_redirect_addr_in (ex_redirect_addr_in),
    .ex_br_valid_in      (ex_br_valid_in),
    .ex_br_pc_in         (ex_br_pc_in),
    .ex_br_taken_in      (ex_br_taken_in),
    .ex_br_target_in     (ex_br_target_in),
    .pc_out              (pc_out),
    .pred_taken_out      (pred_taken_out),
    .pred_target_out     (pred_target_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; stall_in = 6'd0;
    ex_redirect_in = 1'b0; ex_redirect_addr_in = 32'd0;
    ex_br_valid_in = 1'b0; ex_br_pc_in = 32'd0;
    ex_br_taken_in = 1'b0; ex_br_target_in = 32'd0;
  endtask

  // Inputs are driven at the falling edge; one rising edge later outputs are sampled at the next falling edge
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    idle();
  endtask

  task automatic redirect(input logic [31:0] a);
    ex_redirect_in = 1'b1; ex_redirect_addr_in = a;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ex_br_valid_in = 1'b1; ex_br_pc_in = pc; ex_br_taken_in = tk; ex_br_target_in = tgt;
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    check({tag, " pc"}, pc_out, pc);
    check({tag, " taken"}, {31'd0, pred_taken_out}, {31'd0, tk});
    check({tag, " target"}, pred_target_out, tgt);
  endtask

  initial begin
    idle();
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    expect_pred("reset", 32'h0, 1'b0, 32'h4);

    stall_in[0] = 1'b1; tick(); expect_pred("adv1", 32'h4, 1'b0, 32'h8);
    stall_in[0] = 1'b1; tick(); expect_pred("adv2", 32'h8, 1'b0, 32'hC);
    stall_in[0] = 1'b1; tick(); expect_pred("adv3", 32'hC, 1'b0, 32'h10);
    tick(); check("hold pc", pc_out, 32'hC);

    redirect(32'h8); tick(); check("redir to 8", pc_out, 32'h8);
    redirect(32'h100); stall_in[0] = 1'b1; tick();
    check("redir beats advance", pc_out, 32'h100);

    // Allocate 0x10 -> 0x40 while steering the PC there in the same cycle
    train(32'h10, 1'b1, 32'h40); redirect(32'h10); tick();
    expect_pred("trained", 32'h10, 1'b1, 32'h40);
    stall_in[0] = 1'b1; tick();
    expect_pred("follow target", 32'h40, 1'b0, 32'h44);

    // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10
    redirect(32'h10); train(32'h10, 1'b0, 32'h0); tick();
    expect_pred("ctr 01", 32'h10, 1'b0, 32'h14);
    train(32'h10, 1'b1, 32'h40); tick();
    check("ctr 10 taken", {31'd0, pred_taken_out}, 32'd1);
    train(32'h10, 1'b1, 32'h48); tick();
    check("ctr 11 target", pred_target_out, 32'h48);
    train(32'h10, 1'b0, 32'h0); tick();
    expect_pred("ctr 11->10", 32'h10, 1'b1, 32'h48);

    // 0x50 shares index 4 with 0x10 and evicts it
    train(32'h50, 1'b1, 32'h80); tick();
    expect_pred("alias miss", 32'h10, 1'b0, 32'h14);
    redirect(32'h50); tick();
    expect_pred("alias hit", 32'h50, 1'b1, 32'h80);

    // Freeze: everything asserted with rdy low must leave all state alone
    for (int i = 0; i < 2; i++) begin
      rdy_in = 1'b0; redirect(32'h200); stall_in[0] = 1'b1;
      train(32'h50, 1'b0, 32'h0);
      tick();
    end
    expect_pred("frozen", 32'h50, 1'b1, 32'h80);
    train(32'h50, 1'b0, 32'h0); tick();
    expect_pred("after thaw", 32'h50, 1'b0, 32'h54);

    redirect(32'hFFFF_FFFC); tick();
    expect_pred("wrap pre", 32'hFFFF_FFFC, 1'b0, 32'h0);
    stall_in[0] = 1'b1; tick();
    check("wrap pc", pc_out, 32'h0);

    // Reset discards a same-cycle redirect and update, and clears the table
    train(32'h50, 1'b1, 32'h90); redirect(32'h50); tick();
    check("retrain 50", pred_target_out, 32'h90);
    rst_in = 1'b1; redirect(32'h300); train(32'h0, 1'b1, 32'h44); tick();
    expect_pred("mid reset", 32'h0, 1'b0, 32'h4);
    redirect(32'h50); tick();
    expect_pred("table cleared", 32'h50, 1'b0, 32'h54);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Sits at the front of the pipeline between the stall controller, the EX stage and IF. It supplies the fetch address each cycle. On an IF advance it jumps to a predicted target, or falls through to PC+STEP. EX trains the BTB and redirects the PC on mispredicts.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and target width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 0, pc_out value after reset.
- STEP, 4, fall-through increment.

Ports:
- clk_in  in  1  Single clock; all state updates on the rising edge.
- rst_in  in  1  Synchronous, active-high reset.
- rdy_in  in  1  Global ready; when 0, all state holds (PC, BTB, counters).
- stall_in  in  6  Stall-controller vector; bit 0 = 1 means IF consumed pc_out this cycle and the PC advances; bits 5:1 unused.
- ex_redirect_in  in  1  EX mispredict or flush; load ex_redirect_addr_in.
- ex_redirect_addr_in  in  ADDR_WIDTH  Correct next PC.
- ex_br_valid_in  in  1  A resolved conditional branch or jump is reported this cycle.
- ex_br_pc_in  in  ADDR_WIDTH  PC of the resolved branch.
- ex_br_taken_in  in  1  Resolved direction.
- ex_br_target_in  in  ADDR_WIDTH  Resolved taken target.
- pc_out  out  ADDR_WIDTH  Current fetch address (registered).
- pred_taken_out  out  1  Prediction for pc_out; travels with the instruction to EX.
- pred_target_out  out  ADDR_WIDTH  Predicted target for pc_out. Equals pc_out+STEP when pred_taken_out = 0.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_WIDTH-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup is combinational on the registered pc_out.
- hit = valid && tag match. pred_taken_out = hit && ctr[1]. pred_target_out = pred_taken_out ? entry.target : pc_out+STEP.
- Next PC, in priority order, applied only when rdy_in = 1:
  1. ex_redirect_in → ex_redirect_addr_in.
  2. stall_in[0] → pred_target_out.
  3. Otherwise hold.
- Redirect wins over a simultaneous advance.
- BTB update applies only when rdy_in = 1 and ex_br_valid_in = 1. It is indexed and tagged by ex_br_pc_in.
  - On a hit: the counter saturates up if taken, down if not taken, within 00..11. The target is overwritten with ex_br_target_in when taken.
  - On a miss with taken: allocate the entry (valid = 1, new tag, target, ctr = 10), replacing any occupant.
  - On a miss with not taken: no change.
- The update is independent of the redirect; both can occur in the same cycle.
- Arithmetic: pc_out+STEP wraps modulo 2^ADDR_WIDTH. The low two PC bits are not used for index or tag.

## Timing
- Reset (rst_in = 1 at an edge; overrides rdy_in):
  - pc_out = RESET_PC.
  - All valid bits = 0 and all counters = 01.
  - pred_taken_out = 0 and pred_target_out = RESET_PC+STEP the following cycle.
- Reset mid-operation discards any pending redirect or update in that cycle.
- PC latency: 1 cycle. A redirect or advance sampled at edge N is visible on pc_out after edge N.
- Prediction outputs change in the same cycle as pc_out; there are no extra registers.
- Update latency: a BTB write at edge N affects lookups from after edge N.
- A lookup and update to the same index in the same cycle: the lookup sees the pre-update contents.
- rdy_in = 0 freezes all state regardless of the other inputs. Outputs stay stable because they derive from the frozen state.

## Test plan
- Reset then advance: rst_in = 1 for 1 cycle, then stall_in[0] = 1 for 3 cycles with defaults → pc_out 0x0, 0x4, 0x8, 0xC; pred_taken_out = 0 throughout. With stall_in[0] = 0, pc_out holds.
- Redirect priority: pc_out = 0x8, ex_redirect_in = 1 with addr 0x100 and stall_in[0] = 1 in the same cycle → pc_out = 0x100 next cycle.
- Training: report branch pc 0x10, taken, target 0x40. Later pc_out = 0x10 → pred_taken_out = 1, pred_target_out = 0x40; an advance yields pc_out = 0x40.
- Hysteresis: from ctr = 10 at 0x10, one not-taken update → ctr 01, pred_taken_out = 0. Two taken updates → 11. One not-taken update → 10, prediction still taken.
- Aliasing and freeze:
  - A taken branch at 0x50 (same index as 0x10 for 16 entries) replaces the 0x10 entry; 0x10 then misses.
  - With rdy_in = 0 plus redirect, advance and update all asserted → no change in pc_out or the BTB.
- Wrap: pc_out = 0xFFFFFFFC with an advance and no hit → pc_out = 0x00000000.
